// File: rtl/mac_accum.sv
// mac_accum: signed multiply-accumulate that emits one saturated sum per LEN accepted operand pairs.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake for in_a, in_b (signed DW-bit)
//   out_valid/out_ready : result handshake for out_data (signed AW-bit)
//   out_sat             : the held result clamped at least once while it was formed
module mac_accum #(
    parameter int DW  = 16,
    parameter int AW  = 32,
    parameter int LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_data,
    output logic                 out_sat
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [AW-1:0] MAX_V = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] MIN_V = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {ACC, HOLD} state_t;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 sat_flag;
    logic signed [2*DW-1:0] prod;
    logic signed [AW:0]   sum;
    logic signed [AW-1:0] sat_sum;
    logic                 ovf;
    logic                 accept;
    logic                 last;
    logic                 drain;

    assign prod = (2*DW)'(in_a) * (2*DW)'(in_b);
    // One guard bit: overflow shows up as the top two bits of the sum disagreeing.
    assign sum     = (AW+1)'(acc) + (AW+1)'(prod);
    assign ovf     = sum[AW] ^ sum[AW-1];
    assign sat_sum = ovf ? (sum[AW] ? MIN_V : MAX_V) : sum[AW-1:0];

    assign out_valid = (state == HOLD);
    assign in_ready  = !(out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last      = (cnt == CW'(LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (accept && last) begin
            // Completing a group wins over a same-cycle drain, so the new result stays valid.
            state    <= HOLD;
            out_data <= sat_sum;
            out_sat  <= sat_flag | ovf;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (accept) begin
                acc      <= sat_sum;
                cnt      <= cnt + CW'(1);
                sat_flag <= sat_flag | ovf;
            end
            if (drain)
                state <= ACC;
        end
    end
endmodule
